// File: rtl/nrs_ls_estimator_pkg.sv
// rtl/nrs_ls_estimator_pkg.sv - shared constants and FSM encoding for the NRS LS estimator
package nrs_ls_estimator_pkg;

    localparam int WIDTH_RE_DEFAULT = 16;
    localparam int NRS_ADDR_STEP    = 2;
    localparam int NRS_SYM_STEP     = 4;

    typedef enum logic [2:0] {
        WAIT_GEN,
        ACK,
        RD0,
        RD1,
        APPLY
    } est_state_t;

endpackage

// File: rtl/nrs_re_fifo2.sv
// rtl/nrs_re_fifo2.sv - two-entry FIFO buffering received NRS REs
module nrs_re_fifo2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_tdata,
    input  logic              in_tvalid,
    output logic              in_tready,
    output logic              full,
    output logic [DATA_W-1:0] out_tdata,
    output logic              out_tvalid,
    input  logic              out_tready
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign full       = (count == 2'd2);
    assign out_tvalid = (count != 2'd0);
    assign out_tdata  = mem[rd_ptr];
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign in_tready  = !full || out_tready;
    assign do_push    = in_tvalid && in_tready;
    assign do_pop     = out_tready && out_tvalid;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/nrs_ls_estimator.sv
// rtl/nrs_ls_estimator.sv - least-squares channel estimate on QPSK NRS resource elements
module nrs_ls_estimator
    import nrs_ls_estimator_pkg::*;
#(
    parameter int WIDTH_RE = WIDTH_RE_DEFAULT,
    parameter int LINES    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       new_frame,
    input  logic                       NRS_gen_ready,
    input  logic                       nrs_est_r,
    input  logic                       nrs_est_i,
    output logic                       est_ack,
    output logic [LINES-1:0]           rd_addr_est,
    input  logic                       re_valid,
    output logic                       re_ready,
    input  logic signed [WIDTH_RE-1:0] re_r,
    input  logic signed [WIDTH_RE-1:0] re_i,
    output logic                       h_valid,
    output logic signed [WIDTH_RE:0]   h_r,
    output logic signed [WIDTH_RE:0]   h_i,
    output logic                       h_idx
);

    est_state_t                state;
    est_state_t                state_nx;
    logic [LINES-1:0]          base;
    logic                      pat0_r, pat0_i, pat1_r, pat1_i;
    logic                      sym_idx;
    logic                      ready_en;
    logic                      pop;
    logic                      push;
    logic                      fifo_full;
    logic                      fifo_valid;
    logic                      fifo_in_ready;
    logic [2*WIDTH_RE-1:0]     fifo_data;
    logic                      c_r, c_i;
    logic signed [WIDTH_RE:0]  y_r, y_i;
    logic signed [WIDTH_RE:0]  sr_yr, sr_yi, si_yr, si_yi;
    logic signed [WIDTH_RE:0]  est_r, est_i;

    // Ready stays low through reset and rises one cycle after it is released.
    assign re_ready = ready_en && !fifo_full;
    assign push     = re_valid && re_ready && !new_frame;

    nrs_re_fifo2 #(
        .DATA_W (2*WIDTH_RE)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (new_frame),
        .in_tdata   ({re_r, re_i}),
        .in_tvalid  (push),
        .in_tready  (fifo_in_ready),
        .full       (fifo_full),
        .out_tdata  (fifo_data),
        .out_tvalid (fifo_valid),
        .out_tready (pop)
    );

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            WAIT_GEN: if (NRS_gen_ready) state_nx = ACK;
            ACK:      state_nx = RD0;
            RD0:      state_nx = RD1;
            RD1:      state_nx = APPLY;
            APPLY: begin
                if (fifo_valid) begin
                    pop = 1'b1;
                    if (sym_idx) state_nx = WAIT_GEN;
                end
            end
            default:  state_nx = WAIT_GEN;
        endcase
        if (new_frame) begin
            state_nx = WAIT_GEN;
            pop      = 1'b0;
        end
    end

    assign est_ack     = (state == ACK);
    assign rd_addr_est = (state == RD1) ? base + LINES'(NRS_ADDR_STEP) : base;

    // h = y * conj(q) with q in {+-1 +- j}: only sign flips and add/subtract.
    assign c_r   = sym_idx ? pat1_r : pat0_r;
    assign c_i   = sym_idx ? pat1_i : pat0_i;
    assign y_r   = {fifo_data[2*WIDTH_RE-1], fifo_data[2*WIDTH_RE-1 -: WIDTH_RE]};
    assign y_i   = {fifo_data[WIDTH_RE-1], fifo_data[WIDTH_RE-1:0]};
    assign sr_yr = c_r ? -y_r : y_r;
    assign sr_yi = c_r ? -y_i : y_i;
    assign si_yr = c_i ? -y_r : y_r;
    assign si_yi = c_i ? -y_i : y_i;
    assign est_r = sr_yr + si_yi;
    assign est_i = sr_yi - si_yr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT_GEN;
            base     <= '0;
            pat0_r   <= 1'b0;
            pat0_i   <= 1'b0;
            pat1_r   <= 1'b0;
            pat1_i   <= 1'b0;
            sym_idx  <= 1'b0;
            ready_en <= 1'b0;
            h_valid  <= 1'b0;
            h_r      <= '0;
            h_i      <= '0;
            h_idx    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            state    <= state_nx;
            h_valid  <= pop;
            if (new_frame) begin
                base    <= '0;
                sym_idx <= 1'b0;
            end else begin
                if (state == RD0) begin
                    pat0_r <= nrs_est_r;
                    pat0_i <= nrs_est_i;
                end
                if (state == RD1) begin
                    pat1_r <= nrs_est_r;
                    pat1_i <= nrs_est_i;
                end
                if (pop) begin
                    sym_idx <= ~sym_idx;
                    if (sym_idx) base <= base + LINES'(NRS_SYM_STEP);
                end
            end
            if (pop) begin
                h_r   <= est_r;
                h_i   <= est_i;
                h_idx <= sym_idx;
            end
        end
    end

endmodule

// File: tb/tb_nrs_ls_estimator.sv
// tb/tb_nrs_ls_estimator.sv - self-checking bench for nrs_ls_estimator
module tb_nrs_ls_estimator;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                new_frame;
    logic                NRS_gen_ready;
    logic                nrs_est_r;
    logic                nrs_est_i;
    logic                est_ack;
    logic [3:0]          rd_addr_est;
    logic                re_valid;
    logic                re_ready;
    logic signed [W-1:0] re_r;
    logic signed [W-1:0] re_i;
    logic                h_valid;
    logic signed [W:0]   h_r;
    logic signed [W:0]   h_i;
    logic                h_idx;

    bit gen_r [16];
    bit gen_i [16];

    typedef struct {
        bit cr0, ci0, cr1, ci1;
        int y0r, y0i, y1r, y1i;
        int h0r, h0i, h1r, h1i;
    } vec_t;

    typedef struct {
        int idx;
        int hr;
        int hi;
    } hres_t;

    hres_t obs_q [$];
    hres_t exp_q [$];
    vec_t  vecs  [8];
    int    checks   = 0;
    int    errors   = 0;
    int    ack_cnt  = 0;
    int    exp_base = 0;

    always #5 clk = ~clk;

    assign nrs_est_r = gen_r[rd_addr_est];
    assign nrs_est_i = gen_i[rd_addr_est];

    nrs_ls_estimator #(.WIDTH_RE(W), .LINES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .new_frame     (new_frame),
        .NRS_gen_ready (NRS_gen_ready),
        .nrs_est_r     (nrs_est_r),
        .nrs_est_i     (nrs_est_i),
        .est_ack       (est_ack),
        .rd_addr_est   (rd_addr_est),
        .re_valid      (re_valid),
        .re_ready      (re_ready),
        .re_r          (re_r),
        .re_i          (re_i),
        .h_valid       (h_valid),
        .h_r           (h_r),
        .h_i           (h_i),
        .h_idx         (h_idx)
    );

    always @(negedge clk) begin
        if (h_valid === 1'b1) obs_q.push_back('{int'(h_idx), int'(h_r), int'(h_i)});
        if (est_ack === 1'b1) ack_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // y * conj(q) as a plain complex product, q = (1-2c_r) + j(1-2c_i)
    function automatic int mdl_hr(bit cr, bit ci, int yr, int yi);
        int qr = 1 - 2 * int'(cr);
        int qi = 1 - 2 * int'(ci);
        return yr * qr + yi * qi;
    endfunction

    function automatic int mdl_hi(bit cr, bit ci, int yr, int yi);
        int qr = 1 - 2 * int'(cr);
        int qi = 1 - 2 * int'(ci);
        return yi * qr - yr * qi;
    endfunction

    function automatic int trunc17(input int v);
        logic signed [16:0] t;
        t = v[16:0];
        return int'(t);
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.cr0 = bit'($urandom_range(0, 1));
        v.ci0 = bit'($urandom_range(0, 1));
        v.cr1 = bit'($urandom_range(0, 1));
        v.ci1 = bit'($urandom_range(0, 1));
        v.y0r = int'($urandom_range(0, 65535)) - 32768;
        v.y0i = int'($urandom_range(0, 65535)) - 32768;
        v.y1r = int'($urandom_range(0, 65535)) - 32768;
        v.y1i = int'($urandom_range(0, 65535)) - 32768;
        v.h0r = mdl_hr(v.cr0, v.ci0, v.y0r, v.y0i);
        v.h0i = mdl_hi(v.cr0, v.ci0, v.y0r, v.y0i);
        v.h1r = mdl_hr(v.cr1, v.ci1, v.y1r, v.y1i);
        v.h1i = mdl_hi(v.cr1, v.ci1, v.y1r, v.y1i);
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_gen(input int b, input bit cr0, input bit ci0, input bit cr1, input bit ci1);
        for (int a = 0; a < 16; a++) begin
            gen_r[a] = bit'($urandom_range(0, 1));
            gen_i[a] = bit'($urandom_range(0, 1));
        end
        gen_r[b]            = cr0;
        gen_i[b]            = ci0;
        gen_r[(b + 2) % 16] = cr1;
        gen_i[(b + 2) % 16] = ci1;
    endtask

    task automatic push_re(input int yr, input int yi);
        int k = 0;
        re_r     = W'(yr);
        re_i     = W'(yi);
        re_valid = 1'b1;
        while (k < 30) begin
            if (re_ready === 1'b1) break;
            @(negedge clk);
            k++;
        end
        chk("re_accept", re_ready, 1);
        @(negedge clk);
        re_valid = 1'b0;
    endtask

    task automatic wait_ack();
        int k = 0;
        while (est_ack !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ack_seen", est_ack, 1);
    endtask

    task automatic expect_vec(input vec_t v);
        exp_q.push_back('{0, trunc17(v.h0r), trunc17(v.h0i)});
        exp_q.push_back('{1, trunc17(v.h1r), trunc17(v.h1i)});
    endtask

    task automatic collect(input int n);
        int    k = 0;
        hres_t o;
        hres_t e;
        while (obs_q.size() < n && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("h_count", obs_q.size(), n);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk("h_idx", o.idx, e.idx);
            chk("h_r", o.hr, e.hr);
            chk("h_i", o.hi, e.hi);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // The first (2 - n_push) REs of v are expected to be in the FIFO already.
    task automatic run_symbol(input vec_t v, input int n_push);
        int a0;
        set_gen(exp_base, v.cr0, v.ci0, v.cr1, v.ci1);
        if (n_push == 2) push_re(v.y0r, v.y0i);
        push_re(v.y1r, v.y1i);
        expect_vec(v);
        a0 = ack_cnt;
        NRS_gen_ready = 1'b1;
        wait_ack();
        NRS_gen_ready = 1'b0;
        chk("ack_addr", rd_addr_est, exp_base);
        @(negedge clk);
        chk("rd0_addr", rd_addr_est, exp_base);
        @(negedge clk);
        chk("rd1_addr", rd_addr_est, (exp_base + 2) % 16);
        collect(2);
        chk("ack_once", ack_cnt - a0, 1);
        exp_base = (exp_base + 4) % 16;
    endtask

    initial begin
        vec_t va;
        vec_t vb;
        int   k;

        rst           = 1'b1;
        new_frame     = 1'b0;
        NRS_gen_ready = 1'b0;
        re_valid      = 1'b0;
        re_r          = '0;
        re_i          = '0;
        for (int a = 0; a < 16; a++) begin
            gen_r[a] = 1'b0;
            gen_i[a] = 1'b0;
        end

        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1000, 200, 1000, 200, 1200, -800, -1200, 800};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, -32768, 0, -32768, -32768, 32768, 32768, -65536, 0};
        for (int i = 2; i < 8; i++) vecs[i] = rand_vec();

        repeat (3) @(negedge clk);
        chk("rst_est_ack", est_ack, 0);
        chk("rst_rd_addr", rd_addr_est, 0);
        chk("rst_re_ready", re_ready, 0);
        chk("rst_h_valid", h_valid, 0);
        chk("rst_h_r", h_r, 0);
        chk("rst_h_i", h_i, 0);
        chk("rst_h_idx", h_idx, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", re_ready, 1);

        // Eight symbols walk the read base through 0,4,8,12 twice.
        for (int i = 0; i < 8; i++) run_symbol(vecs[i], 2);

        // Three REs arrive before the generator is ready.
        va = rand_vec();
        vb = rand_vec();
        set_gen(exp_base, va.cr0, va.ci0, va.cr1, va.ci1);
        push_re(va.y0r, va.y0i);
        push_re(va.y1r, va.y1i);
        expect_vec(va);
        re_r     = W'(vb.y0r);
        re_i     = W'(vb.y0i);
        re_valid = 1'b1;
        @(negedge clk);
        chk("full_not_ready", re_ready, 0);
        NRS_gen_ready = 1'b1;
        wait_ack();
        NRS_gen_ready = 1'b0;
        k = 0;
        while (k < 30) begin
            if (re_ready === 1'b1) begin
                @(negedge clk);
                re_valid = 1'b0;
                break;
            end
            @(negedge clk);
            k++;
        end
        chk("third_accepted", re_valid, 0);
        re_valid = 1'b0;
        collect(2);
        exp_base = (exp_base + 4) % 16;
        run_symbol(vb, 1);

        // new_frame in RD1 with one RE buffered.
        va = rand_vec();
        set_gen(exp_base, va.cr0, va.ci0, va.cr1, va.ci1);
        push_re(111, 222);
        NRS_gen_ready = 1'b1;
        wait_ack();
        NRS_gen_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("nf_in_rd1", rd_addr_est, (exp_base + 2) % 16);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        repeat (5) @(negedge clk);
        chk("nf_no_h", obs_q.size(), 0);
        chk("nf_addr", rd_addr_est, 0);
        chk("nf_ready", re_ready, 1);
        exp_base = 0;
        run_symbol(va, 2);

        // Reset while APPLY waits for the second RE.
        va = rand_vec();
        set_gen(exp_base, va.cr0, va.ci0, va.cr1, va.ci1);
        push_re(va.y0r, va.y0i);
        exp_q.push_back('{0, trunc17(va.h0r), trunc17(va.h0i)});
        NRS_gen_ready = 1'b1;
        wait_ack();
        NRS_gen_ready = 1'b0;
        collect(1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_est_ack", est_ack, 0);
        chk("mid_rst_rd_addr", rd_addr_est, 0);
        chk("mid_rst_re_ready", re_ready, 0);
        chk("mid_rst_h_valid", h_valid, 0);
        chk("mid_rst_h_r", h_r, 0);
        chk("mid_rst_h_i", h_i, 0);
        chk("mid_rst_h_idx", h_idx, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_rise", re_ready, 1);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_h", obs_q.size(), 0);
        exp_base = 0;
        run_symbol(rand_vec(), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
